// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding, default widths and counter sizing for the divider
package divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Step counter width; the extra bit keeps DW-1 representable for any DW.
    function automatic int cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift/subtract step
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   r_in,
    input  logic          d_bit,
    input  logic [VW-1:0] v,
    output logic [VW:0]   r_out,
    output logic          q_bit
);

    logic [VW:0] t;

    // The shift drops r_in's MSB, which is always 0 because R < V after each step.
    always_comb begin
        t = (r_in << 1) | {{VW{1'b0}}, d_bit};
        if (t >= {1'b0, v}) begin
            r_out = t - {1'b0, v};
            q_bit = 1'b1;
        end else begin
            r_out = t;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider; optional dbz output under DIVIDER_DBZ_FLAG_EN
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    output logic          dbz
`endif
);

    localparam int CW = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] q_reg;
    logic [DW-1:0] q_next;
    logic [VW-1:0] v_reg;
    logic [VW:0]   r_reg;
    logic [VW:0]   r_next;
    logic          q_bit;
    logic [CW-1:0] cnt;
    logic          last_step;
    logic          v_zero;

    div_step #(.VW(VW)) u_step (
        .r_in  (r_reg),
        .d_bit (d_reg[DW-1]),
        .v     (v_reg),
        .r_out (r_next),
        .q_bit (q_bit)
    );

    assign q_next    = (q_reg << 1) | {{(DW-1){1'b0}}, q_bit};
    assign last_step = (cnt == CNT_LAST);
    assign v_zero    = (v_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results are only touched on the final step, so they stay valid until the next run ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg     <= '0;
            q_reg     <= '0;
            v_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
            dbz       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        d_reg <= dividend;
                        v_reg <= divisor;
                        r_reg <= '0;
                        q_reg <= '0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    d_reg <= d_reg << 1;
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        if (v_zero) begin
                            quotient  <= '1;
                            remainder <= '0;
                        end else begin
                            quotient  <= q_next;
                            remainder <= r_next[VW-1:0];
                        end
`ifdef DIVIDER_DBZ_FLAG_EN
                        dbz <= v_zero;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
